// File: rtl/embedded_system_mem_test_master.sv
// embedded_system_mem_test_master
// Memory test master for an Avalon-MM slave. One pass writes an incrementing
// pattern (seed+i) to num_words consecutive word addresses starting at
// base_word. It then reads them back with up to MAX_OUTSTANDING pipelined
// reads and counts mismatching words.
//
// Ports
//   clk, reset          single clock, synchronous active-high reset
//   start               one-cycle pass request (accepted in IDLE/DONE only)
//   base_word           first word address of the pass
//   num_words           words to test, 0..2^ADDR_W
//   seed                pattern seed
//   busy, done          pass in progress / pass finished
//   err_count           mismatching words in last pass (saturating)
//   first_err_addr      word address of first mismatch in last pass
//   avm_*               Avalon-MM master (byte addressed, 32-bit data)
//   state_dbg           current FSM state encoding (IDLE=0 .. DONE=4)
//
// Handshake: a request (avm_read or avm_write) is accepted on a rising edge
// where it is high and avm_waitrequest is low. Address and data are held
// stable while waitrequest is high. Read data returns in request order on
// avm_readdatavalid, one word per cycle.
module embedded_system_mem_test_master #(
  parameter int ADDR_W          = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_word,
  input  logic [ADDR_W:0]   num_words,
  input  logic [31:0]       seed,
  output logic              busy,
  output logic              done,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W+1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest,
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_READ  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0]    MAX_OUT = 4'(MAX_OUTSTANDING);
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   num_q;
  logic [31:0]       seed_q;
  logic [ADDR_W:0]   wr_idx;   // next word to write
  logic [ADDR_W:0]   rd_idx;   // next word to read
  logic [ADDR_W:0]   rx_idx;   // next response expected
  logic [3:0]        outstanding;

  logic [ADDR_W-1:0] wr_word, rd_word, rx_word;
  logic              can_read, wr_acc, rd_acc, rx_take, accept_start;
  logic [31:0]       rx_expect;

  // Address arithmetic is ADDR_W wide, so passes wrap past the top of memory.
  assign wr_word   = base_q + wr_idx[ADDR_W-1:0];
  assign rd_word   = base_q + rd_idx[ADDR_W-1:0];
  assign rx_word   = base_q + rx_idx[ADDR_W-1:0];
  assign rx_expect = seed_q + 32'(rx_idx);

  assign can_read     = (outstanding < MAX_OUT) && (rd_idx < num_q);
  assign wr_acc       = avm_write && !avm_waitrequest;
  assign rd_acc       = avm_read && !avm_waitrequest;
  // Responses outside an active read phase are stale (e.g. from an
  // abandoned pass) and are dropped.
  assign rx_take      = avm_readdatavalid && (state == S_READ || state == S_DRAIN);
  assign accept_start = start && (state == S_IDLE || state == S_DONE);

  assign busy           = (state == S_WRITE) || (state == S_READ) || (state == S_DRAIN);
  assign done           = (state == S_DONE);
  assign avm_byteenable = 4'hF;
  assign state_dbg      = state;

  always_comb begin
    state_n       = state;
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_address   = '0;
    avm_writedata = '0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) state_n = (num_words == '0) ? S_DONE : S_WRITE;
      end
      S_WRITE: begin
        avm_write     = 1'b1;
        avm_address   = {wr_word, 2'b00};
        avm_writedata = seed_q + 32'(wr_idx);
        if (!avm_waitrequest && wr_idx == num_q - ONE) state_n = S_READ;
      end
      S_READ: begin
        // Gated on the registered count: the request drops while at limit.
        if (can_read) begin
          avm_read    = 1'b1;
          avm_address = {rd_word, 2'b00};
          if (!avm_waitrequest && rd_idx == num_q - ONE) state_n = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (outstanding == 4'd0 && rx_idx == num_q) state_n = S_DONE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      base_q         <= '0;
      num_q          <= '0;
      seed_q         <= '0;
      wr_idx         <= '0;
      rd_idx         <= '0;
      rx_idx         <= '0;
      outstanding    <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
    end else begin
      state <= state_n;
      if (accept_start) begin
        base_q         <= base_word;
        num_q          <= num_words;
        seed_q         <= seed;
        wr_idx         <= '0;
        rd_idx         <= '0;
        rx_idx         <= '0;
        outstanding    <= '0;
        err_count      <= '0;
        first_err_addr <= '0;
      end else begin
        if (wr_acc) wr_idx <= wr_idx + ONE;
        if (rd_acc) rd_idx <= rd_idx + ONE;
        case ({rd_acc, rx_take})
          2'b10:   outstanding <= outstanding + 4'd1;
          2'b01:   outstanding <= outstanding - 4'd1;
          default: outstanding <= outstanding;
        endcase
        if (rx_take) begin
          rx_idx <= rx_idx + ONE;
          if (avm_readdata != rx_expect) begin
            if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            // err_count never returns to zero within a pass, so zero
            // identifies the first mismatch.
            if (err_count == 16'd0) first_err_addr <= rx_word;
          end
        end
      end
    end
  end

endmodule

// File: doc/embedded_system_mem_test_master.md
EMBEDDED_SYSTEM_MEM_TEST_MASTER -- requirements
Module: embedded_system_mem_test_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, word-address width of the target memory.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, maximum read transactions in flight (1..15).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a fill/check pass.
REQ-006 SHALL have port base_word  input  ADDR_W  first word address of the pass.
REQ-007 SHALL have port num_words  input  ADDR_W+1  number of words to test (0..2^ADDR_W).
REQ-008 SHALL have port seed  input  32  pattern seed.
REQ-009 SHALL have port busy  output  1  high while a pass is in progress.
REQ-010 SHALL have port done  output  1  high from pass completion until next accepted start.
REQ-011 SHALL have port err_count  output  16  mismatching words in last pass, saturating.
REQ-012 SHALL have port first_err_addr  output  ADDR_W  word address of first mismatch.
REQ-013 SHALL have port avm_address  output  ADDR_W+2  Avalon-MM byte address (word address x4).
REQ-014 SHALL have ports avm_read, avm_write  output  1 each  Avalon-MM read/write requests.
REQ-015 SHALL have ports avm_writedata  output  32, avm_byteenable  output  4 (always 4'hF).
REQ-016 SHALL have ports avm_readdata  input  32, avm_readdatavalid  input  1, avm_waitrequest  input  1.

Function
REQ-017 SHALL implement states IDLE, WRITE, READ, DRAIN, DONE; busy=1 exactly in WRITE/READ/DRAIN.
REQ-018 SHALL accept start only in IDLE or DONE; start while busy ignored; on acceptance latch base_word, num_words, seed, clear err_count, first_err_addr, done.
REQ-019 SHALL, on accepted start with num_words=0, go to DONE next cycle with err_count=0, no bus traffic.
REQ-020 SHALL define word i (0..num_words-1) address = (base_word+i) mod 2^ADDR_W and pattern = (seed+i) mod 2^32.
REQ-021 SHALL in WRITE assert avm_write for word i, holding address/data stable while avm_waitrequest=1; advance i on cycle with avm_write=1 and avm_waitrequest=0; back-to-back writes with no idle cycle.
REQ-022 SHALL enter READ the cycle after the last write is accepted; avm_read and avm_write never both high.
REQ-023 SHALL in READ issue reads in order while outstanding<MAX_OUTSTANDING and issued<num_words; read accepted on avm_read=1 and avm_waitrequest=0.
REQ-024 SHALL increment outstanding on read acceptance, decrement on avm_readdatavalid, leave unchanged when both occur in the same cycle.
REQ-025 SHALL deassert avm_read in the cycle outstanding would exceed MAX_OUTSTANDING; no read request held while at limit.
REQ-026 SHALL enter DRAIN after last read accepted; enter DONE the cycle after outstanding reaches 0 with all num_words responses received.
REQ-027 SHALL compare each readdatavalid word in return order against pattern of its index k; on mismatch increment err_count (saturate at 16'hFFFF) and, if first mismatch of pass, load first_err_addr=(base_word+k).
REQ-028 SHALL ignore avm_readdatavalid in IDLE and DONE.
REQ-029 SHALL wrap addresses past 2^ADDR_W-1 to 0 without error.
REQ-030 SHALL hold err_count and first_err_addr stable in DONE until next accepted start.

Reset
REQ-031 SHALL on reset: state IDLE, busy=0, done=0, err_count=0, first_err_addr=0, avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, outstanding=0.
REQ-032 SHALL, on reset mid-pass, abandon the pass at that edge; responses arriving after reset ignored.

Verification
REQ-033 Ideal memory (1-cycle read latency, waitrequest=0), base=0, num=8, seed=0x1000 -> writes 0x1000..0x1007 to byte addr 0x00..0x1C, done=1, err_count=0.
REQ-034 Memory forcing word 5 to 0 on read, base=0x10, num=8 -> err_count=1, first_err_addr=0x15.
REQ-035 waitrequest high 3 cycles on every access, num=4 -> each request held stable 4 cycles, no duplicates, err_count=0.
REQ-036 base=0xFFFE, num=4, ADDR_W=16 -> word addresses FFFE, FFFF, 0000, 0001; err_count=0.
REQ-037 Read latency 8, MAX_OUTSTANDING=4, num=16 -> outstanding never exceeds 4, done after 16 responses.
REQ-038 Reset asserted during READ with 2 reads outstanding -> next cycle IDLE, busy=0; late readdatavalid leaves err_count=0; start with num=0 -> done next cycle.
